// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared constants, controller states and nonce index type for the job controller.
package bitcoin_pkg;
  localparam int NUM_NONCES   = 16;
  localparam int HEADER_WORDS = 19;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DROP, WAIT_DONE, READ, REPORT} state_e;
  typedef logic [3:0] nonce_t;
endpackage

// File: rtl/bitcoin_min_tracker.sv
// bitcoin_min_tracker: registered running minimum of sampled h0 values; ties keep the earlier index.
module bitcoin_min_tracker
  import bitcoin_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [31:0] i_value,
  input  nonce_t      i_index,
  output logic [31:0] o_min,
  output nonce_t      o_index
);
  logic [31:0] r_min;
  nonce_t      r_idx;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_min <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_min <= '1;
      r_idx <= '0;
    end else if (i_valid && i_value < r_min) begin
      r_min <= i_value;
      r_idx <= i_index;
    end
  end
  assign o_min   = r_min;
  assign o_index = r_idx;
endmodule

// File: rtl/bitcoin_job_ctrl.sv
// bitcoin_job_ctrl: loads a block header into shared memory, runs the nonce hasher,
// then scans the per-nonce h0 results for the minimum and reports it against target.
module bitcoin_job_ctrl
  import bitcoin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] target,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [31:0] hdr_data,
  output logic        hash_start,
  input  logic        hash_done,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        found,
  output logic        timeout,
  output logic [3:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e      r_state, w_next;
  logic [4:0]  r_cnt, w_cnt_nxt, r_rd;
  logic [TW-1:0] r_tmo;
  logic        r_hdr_ready, r_hash_start, r_mem_sel, r_mem_we, r_result_valid, r_found, r_timeout;
  logic [15:0] r_mem_addr;
  logic [31:0] r_mem_wdata, w_min, w_last_min;
  nonce_t      w_min_idx;
  logic        w_hs, w_sample;
  assign w_hs       = hdr_valid & r_hdr_ready;
  assign w_cnt_nxt  = r_cnt + 5'(w_hs);
  assign w_sample   = (r_state == READ) && (r_rd != 5'd0);
  assign w_last_min = (mem_read_data < w_min) ? mem_read_data : w_min;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_hs ? LOAD : IDLE;
      LOAD:      w_next = (r_cnt == 5'(HEADER_WORDS)) ? START : LOAD;
      START:     w_next = WAIT_DROP;
      WAIT_DROP: w_next = WAIT_DONE;
      WAIT_DONE: w_next = hash_done ? READ : (r_tmo == TW'(TIMEOUT_CYCLES - 1)) ? REPORT : WAIT_DONE;
      READ:      w_next = (r_rd == 5'(NUM_NONCES)) ? REPORT : READ;
      REPORT:    w_next = result_ready ? IDLE : REPORT;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hdr_ready    <= 1'b0;
      r_hash_start   <= 1'b0;
      r_mem_sel      <= 1'b1;
      r_mem_we       <= 1'b0;
      r_result_valid <= 1'b0;
      r_found        <= 1'b0;
      r_timeout      <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cnt          <= '0;
      r_rd           <= '0;
      r_tmo          <= '0;
    end else begin
      r_hdr_ready    <= (w_next == IDLE) || (w_next == LOAD && w_cnt_nxt < 5'(HEADER_WORDS));
      r_hash_start   <= (w_next == START);
      r_mem_sel      <= !(w_next inside {START, WAIT_DROP, WAIT_DONE});
      r_mem_we       <= w_hs;
      r_result_valid <= (w_next == REPORT);
      r_cnt          <= (r_state == START) ? '0 : w_cnt_nxt;
      r_rd           <= (r_state == READ) ? r_rd + 5'd1 : '0;
      // counts cycles since the start pulse; the START cycle itself is cycle 0
      r_tmo          <= (r_state inside {WAIT_DROP, WAIT_DONE}) ? r_tmo + TW'(1) : TW'(1);
      if (w_hs) begin
        r_mem_addr  <= message_addr + 16'(r_cnt);
        r_mem_wdata <= hdr_data;
      end else if ((r_state == WAIT_DONE && hash_done) || (r_state == READ && r_rd < 5'(NUM_NONCES - 1)))
        r_mem_addr <= output_addr + 16'(r_state == READ ? r_rd + 5'd1 : 5'd0);
      if (r_state == START) begin
        r_found   <= 1'b0;
        r_timeout <= 1'b0;
      end else if (r_state == WAIT_DONE && w_next == REPORT) begin
        r_found   <= 1'b0;
        r_timeout <= 1'b1;
      end else if (r_state == READ && w_next == REPORT)
        r_found <= w_last_min < target;
    end
  end
  // the tracker sees data for address j one cycle after it was driven
  bitcoin_min_tracker u_min (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (r_state == START),
    .i_valid (w_sample),
    .i_value (mem_read_data),
    .i_index (nonce_t'(r_rd - 5'd1)),
    .o_min   (w_min),
    .o_index (w_min_idx)
  );
  assign hdr_ready      = r_hdr_ready;
  assign hash_start     = r_hash_start;
  assign mem_sel        = r_mem_sel;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign result_valid   = r_result_valid;
  assign found          = r_found;
  assign timeout        = r_timeout;
  assign best_nonce     = w_min_idx;
  assign best_hash      = w_min;
  assign busy           = (r_state != IDLE);
endmodule

// File: tb/tb_bitcoin_job_ctrl.sv
// tb_bitcoin_job_ctrl: shared memory and hasher models around the job controller, with a
// vector table of jobs, randomized jobs checked against a min-search model, and corner sequences.
module tb_bitcoin_job_ctrl;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic [15:0] message_addr = 0, output_addr = 0;
  logic [31:0] target = 0, hdr_data = 0, mem_write_data, mem_read_data, best_hash;
  logic hdr_valid = 0, hdr_ready, hash_start, hash_done = 1, mem_sel, mem_we;
  logic result_valid, result_ready = 0, found, timeout, busy;
  logic [15:0] mem_addr;
  logic [3:0] best_nonce;

  bitcoin_job_ctrl dut (
    .clk(clk), .reset_n(reset_n), .message_addr(message_addr), .output_addr(output_addr),
    .target(target), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data),
    .hash_start(hash_start), .hash_done(hash_done), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .result_valid(result_valid), .result_ready(result_ready), .found(found), .timeout(timeout),
    .best_nonce(best_nonce), .best_hash(best_hash), .busy(busy)
  );

  int checks = 0, errors = 0;
  logic [31:0] mem [65536];
  logic [31:0] h0 [16];
  logic [31:0] hdr_words [19];
  logic [15:0] h_oa = 0;
  int hlat = 3, hcnt = 0, cyc = 0;
  bit hang = 0, drop = 0;

  // Memory with one-cycle read latency, plus a hasher whose done stays stale-high for one cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_sel && mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
    if (hash_start) begin
      drop <= 1;
      hcnt <= hlat;
    end else if (drop) begin
      drop <= 0;
      hash_done <= 0;
    end else if (!hash_done && !hang) begin
      if (hcnt == 0) begin
        for (int n = 0; n < 16; n++) mem[h_oa + 16'(n)] <= h0[n];
        hash_done <= 1;
      end else hcnt <= hcnt - 1;
    end
  end

  typedef struct {int c; logic [15:0] a; logic [31:0] d;} wr_t;
  wr_t wlog[$];
  int starts = 0, start_cyc = 0, rv_cyc = 0;
  logic sel_at_start = 1, rv_prev = 0;
  always @(negedge clk) begin
    if (mem_sel && mem_we) wlog.push_back('{cyc, mem_addr, mem_write_data});
    if (hash_start) begin
      starts++;
      start_cyc = cyc;
      sel_at_start = mem_sel;
    end
    if (result_valid && !rv_prev) rv_cyc = cyc;
    rv_prev = result_valid;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Minimum found by value first, then the earliest nonce holding that value.
  function automatic void model(input logic [31:0] t, output logic [3:0] bn, output logic [31:0] bh, output logic f);
    bh = h0[0];
    for (int n = 1; n < 16; n++) if (h0[n] < bh) bh = h0[n];
    bn = 0;
    for (int n = 15; n >= 0; n--) if (h0[n] == bh) bn = 4'(n);
    f = bh < t;
  endfunction

  task automatic do_reset();
    reset_n = 0;
    @(posedge clk); #1;
    chk("rst_ctl", {hdr_ready, hash_start, mem_we, result_valid, found, timeout, busy, mem_sel}, 8'b0000_0001);
    chk("rst_mem", {mem_addr, mem_write_data}, 0);
    chk("rst_best", {best_nonce, best_hash}, 0);
    reset_n = 1;
    hdr_valid = 0;
  endtask

  task automatic send_header(input bit gaps, input int nwords);
    int i = 0, g = 0;
    bit hs;
    while (i < nwords && g < 400) begin
      hdr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      hdr_data = hdr_words[i];
      hs = hdr_valid && hdr_ready;
      @(posedge clk); #1;
      g++;
      if (hs) i++;
    end
    hdr_valid = 0;
    if (i < nwords) chk("hdr_accept_bound", i, nwords);
  endtask

  task automatic start_job(input logic [15:0] ma, input logic [15:0] oa, input logic [31:0] tgt,
                           input int pat, input bit gaps, input int lat);
    int wb, sb, g;
    message_addr = ma; output_addr = oa; target = tgt; h_oa = oa; hlat = lat;
    for (int i = 0; i < 19; i++) hdr_words[i] = gaps ? $urandom : 32'h1000_0000 + 32'(i);
    for (int n = 0; n < 16; n++)
      h0[n] = pat == 0 ? 32'h9000_0000 - 32'(n * 16) : pat == 1 ? 32'h5 : pat == 2 ? 32'hFFFF_FFFF :
              pat == 3 ? $urandom : 32'($urandom_range(0, 5));
    g = 0;
    while (!hdr_ready && g < 20) begin @(posedge clk); #1; g++; end
    wb = wlog.size();
    sb = starts;
    send_header(gaps, 19);
    chk("hdr_ready_low", hdr_ready, 0);
    g = 0;
    while (starts == sb && g < 30) begin @(posedge clk); #1; g++; end
    repeat (2) @(posedge clk);
    #1;
    chk("start_pulses", starts - sb, 1);
    chk("sel_at_start", sel_at_start, 0);
    chk("wr_count", wlog.size() - wb, 19);
    if (wlog.size() - wb == 19)
      for (int i = 0; i < 19; i++) begin
        chk($sformatf("wr_%0d", i), {wlog[wb+i].a, wlog[wb+i].d}, {ma + 16'(i), hdr_words[i]});
        if (!gaps) chk($sformatf("wr_cyc_%0d", i), wlog[wb+i].c - wlog[wb].c, i);
      end
  endtask

  task automatic finish_job(input logic [3:0] en, input logic [31:0] eh, input logic ef, input logic et, input int hold);
    int g = 0, bad = 0;
    while (!result_valid && g < 6000) begin @(posedge clk); #1; g++; end
    chk("res_valid", result_valid, 1);
    chk("res_vals", {best_nonce, best_hash, found, timeout}, {en, eh, ef, et});
    chk("res_busy", {busy, hdr_ready}, 2'b10);
    if (hold > 0) begin
      hdr_valid = 1;
      repeat (hold) begin
        @(posedge clk); #1;
        if ({result_valid, best_nonce, best_hash, found, timeout, hdr_ready, mem_we} !== {1'b1, en, eh, ef, et, 2'b00}) bad++;
      end
      hdr_valid = 0;
      chk("hold_stable", bad, 0);
    end
    result_ready = 1;
    @(posedge clk); #1;
    result_ready = 0;
    chk("res_clear", {result_valid, busy}, 0);
  endtask

  typedef struct {
    logic [15:0] ma, oa; logic [31:0] tgt; int pat; bit gaps; int lat;
    bit use_model; logic [3:0] en; logic [31:0] eh; logic ef;
  } vec_t;
  vec_t tv[12];

  initial begin
    logic [3:0] en;
    logic [31:0] eh;
    logic ef;
    logic [15:0] ma;
    int g;
    tv[0] = '{16'h0000, 16'h0100, 32'h8FFF_FF20, 0, 0, 5, 0, 4'd15, 32'h8FFF_FF10, 1'b1};
    tv[1] = '{16'h0040, 16'h0200, 32'h0000_0005, 1, 0, 2, 0, 4'd0, 32'h0000_0005, 1'b0};
    tv[2] = '{16'h0300, 16'h0400, 32'hFFFF_FFFF, 2, 1, 0, 0, 4'd0, 32'hFFFF_FFFF, 1'b0};
    tv[3] = '{16'h0500, 16'h0600, 32'h0000_0000, 0, 1, 7, 0, 4'd15, 32'h8FFF_FF10, 1'b0};
    tv[4] = '{16'h0700, 16'h0800, 32'hFFFF_FFFF, 0, 0, 1, 0, 4'd15, 32'h8FFF_FF10, 1'b1};
    tv[5] = '{16'hFFF0, 16'h0010, $urandom, 3, 1, 3, 1, 4'd0, 32'h0, 1'b0};
    for (int k = 6; k < 12; k++) begin
      ma = 16'($urandom);
      tv[k] = '{ma, ma + 16'h0100, 32'h0, 3 + k % 2, 1'($urandom_range(0, 1)), $urandom_range(0, 9), 1, 4'd0, 32'h0, 1'b0};
      tv[k].tgt = tv[k].pat == 4 ? 32'($urandom_range(0, 6)) : $urandom;
    end

    do_reset();
    for (int k = 0; k < 12; k++) begin
      start_job(tv[k].ma, tv[k].oa, tv[k].tgt, tv[k].pat, tv[k].gaps, tv[k].lat);
      if (tv[k].use_model) model(tv[k].tgt, en, eh, ef);
      else begin en = tv[k].en; eh = tv[k].eh; ef = tv[k].ef; end
      finish_job(en, eh, ef, 1'b0, 0);
    end

    // hasher never returns done
    hang = 1;
    start_job(16'h0900, 16'h0A00, 32'd1000, 3, 0, 0);
    finish_job(4'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    chk("tmo_latency", rv_cyc - start_cyc, 4096);
    chk("tmo_no_read", mem_addr, 16'h0912);
    hang = 0;
    g = 0;
    while (!hash_done && g < 50) begin @(posedge clk); #1; g++; end

    // reset while header word 10 is on the bus
    for (int i = 0; i < 19; i++) hdr_words[i] = $urandom;
    message_addr = 16'h0B00;
    g = 0;
    while (!hdr_ready && g < 20) begin @(posedge clk); #1; g++; end
    send_header(0, 10);
    hdr_valid = 1;
    hdr_data = hdr_words[10];
    do_reset();
    start_job(16'h0B00, 16'h0C00, $urandom, 3, 0, 2);
    model(target, en, eh, ef);
    finish_job(en, eh, ef, 1'b0, 0);

    // reset in the middle of the result scan
    start_job(16'h0D00, 16'h0E00, $urandom, 3, 0, 4);
    g = 0;
    while (!(mem_sel && hash_done) && g < 50) begin @(posedge clk); #1; g++; end
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    start_job(16'h0D00, 16'h0E00, $urandom, 4, 1, 1);
    model(target, en, eh, ef);
    finish_job(en, eh, ef, 1'b0, 0);

    // host stalls the result, then a job whose results wrap the address space
    start_job(16'h2000, 16'h2100, 32'h8FFF_FF20, 0, 0, 3);
    finish_job(4'd15, 32'h8FFF_FF10, 1'b1, 1'b0, 50);
    start_job(16'h3000, 16'hFFF8, $urandom, 3, 0, 3);
    model(target, en, eh, ef);
    finish_job(en, eh, ef, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitcoin_job_ctrl.md
Name: bitcoin_job_ctrl

Overview:
Host-side job controller and the initiator for the nonce hasher's memory and start/done interface. It receives a 19-word block header over a valid/ready stream and writes it into shared memory at message_addr. It then pulses the hasher's start, waits for done, and reads back the 16 per-nonce h0 words from output_addr. It returns the nonce with the smallest h0 and whether that h0 beats the target. It owns the shared memory port only while the hasher is idle.

Parameters:
NUM_NONCES, 16, nonces per job (output words read back)
HEADER_WORDS, 19, header words written per job
TIMEOUT_CYCLES, 4096, maximum cycles to wait for hash_done before aborting

Ports:
clk  in  1  single clock; memory is clocked by clk
reset_n  in  1  reset, synchronous active-low (sampled on rising clk)
message_addr  in  16  word address of header region
output_addr  in  16  word address of result region
target  in  32  unsigned threshold; an h0 value wins if strictly below it
hdr_valid  in  1  header word valid
hdr_ready  out  1  controller accepts header word
hdr_data  in  32  header word, in order, word 0 first
hash_start  out  1  one-cycle start pulse to hasher
hash_done  in  1  hasher idle/done level (high whenever hasher idle)
mem_sel  out  1  1 = controller drives shared memory port
mem_we  out  1  memory write enable
mem_addr  out  16  memory word address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data; valid the cycle after address is driven
result_valid  out  1  result available
result_ready  in  1  host consumes result
found  out  1  best_hash < target (0 on timeout)
timeout  out  1  job aborted because hash_done never returned
best_nonce  out  4  nonce index with minimum h0
best_hash  out  32  minimum h0 value
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n low at a rising edge): state=IDLE. hdr_ready, hash_start, mem_we, result_valid, found, timeout and busy are 0. mem_sel=1. mem_addr, mem_write_data, best_nonce and best_hash are 0. Reset mid-job abandons the job immediately; the host must re-send the full header.
- IDLE: hdr_ready=1. The first hdr handshake moves to LOAD and counts as word 0.
- LOAD:
  - hdr_ready=1 while the word count is below HEADER_WORDS.
  - Each handshake at edge N drives mem_we=1, mem_addr=message_addr+i, mem_write_data=word i in cycle N+1. Throughput is one word per cycle; hdr_valid gaps give mem_we=0 in that cycle.
  - After word 18 is accepted, hdr_ready drops. The next cycle carries the last write; the state after that is START.
- START: mem_sel=0 and hash_start=1 for exactly one cycle. The timeout counter clears. Go to WAIT_DROP.
- WAIT_DROP: ignore hash_done for one cycle, because the hasher's done is still stale-high. Go to WAIT_DONE.
- WAIT_DONE:
  - On hash_done=1, take mem_sel=1 and go to READ.
  - If the counter reaches TIMEOUT_CYCLES first, go to REPORT with timeout=1, found=0, best_nonce=0, best_hash=32'hFFFFFFFF.
- READ:
  - Drives mem_addr=output_addr+j for j=0..15 on consecutive cycles, with mem_we=0.
  - The data for address j is sampled one cycle later, so the read phase takes 17 cycles.
  - The running minimum compares unsigned. On a tie the lower nonce index is kept, so only a strictly smaller value replaces the minimum.
  - After sample 15 the state is REPORT, with found=(best_hash<target).
- REPORT: result_valid=1 and outputs are held stable until result_ready=1. On that handshake, result_valid clears next cycle and the state returns to IDLE. hdr_ready stays 0 throughout REPORT, so a new job cannot overlap an unconsumed result.
- Address arithmetic wraps modulo 2^16, e.g. output_addr=16'hFFF8 reads 16'hFFF8..16'h0007.
- target=0 means found is always 0. target=32'hFFFFFFFF means found=1 unless best_hash=32'hFFFFFFFF.

Decomposition:
- Package bitcoin_pkg holds:
  - NUM_NONCES and HEADER_WORDS constants
  - the controller state enum (IDLE, LOAD, START, WAIT_DROP, WAIT_DONE, READ, REPORT)
  - a nonce index typedef of 4 bits
- One sub-module, bitcoin_min_tracker: clear, sample valid, value and index in; registered minimum value and index out; strict-less update rule.

Test Plan:
- Header burst 19 back-to-back words 32'h1000_0000+i, message_addr=16'h0000: mem_we high 19 consecutive cycles, addresses 0..18, data matches; hdr_ready low after word 18; a single hash_start pulse follows.
- Memory model h0[n] = 32'h9000_0000-n*16, target=32'h8FFF_FF20: best_nonce=15, best_hash=32'h8FFF_FF10, found=1.
- All h0 = 32'h0000_0005 with target=32'h0000_0005: best_nonce=0 (tie rule), found=0 (strict compare).
- hash_done held low after start: exactly TIMEOUT_CYCLES later, result_valid=1, timeout=1, found=0, and no memory reads are issued.
- Reset asserted at header word 10 and again during READ: the next cycle shows IDLE outputs; a fresh full job then completes correctly.
- result_ready held low 50 cycles with hdr_valid=1: outputs stay stable, hdr_ready=0; output_addr=16'hFFF8 wrap verified on the next job.
